// File: rtl/lcd_sequencer.sv
// HD44780-style 4-bit LCD write sequencer: power-up wait, nibble/byte init
// sequence, then accepts single-byte writes split into two timed E strobes.
module lcd_sequencer #(
    parameter int POWERUP_DELAY = 750000,
    parameter int LONG_DELAY    = 110000,
    parameter int SHORT_DELAY   = 2500,
    parameter int E_SETUP       = 2,
    parameter int E_WIDTH       = 12,
    parameter int E_HOLD        = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       ready,
    output logic       init_done,
    output logic       rs,
    output logic       e,
    output logic [3:0] d,
    output logic [2:0] state_dbg
);

    // Handshake: a write is accepted on any rising edge where req=1 and
    // ready=1; ready depends on state only, never on req.
    typedef enum logic [2:0] {
        PWR_WAIT, INIT_NIB, INIT_BYTE, IDLE, SEND_HI, SEND_LO, WAIT
    } state_t;

    localparam int PHASE = E_SETUP + E_WIDTH + E_HOLD;
    localparam int MAX_A = (POWERUP_DELAY > LONG_DELAY) ? POWERUP_DELAY : LONG_DELAY;
    localparam int MAX_B = (SHORT_DELAY > PHASE) ? SHORT_DELAY : PHASE;
    localparam int MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_D + 1);

    localparam logic [CW-1:0] PWR_LAST   = CW'(POWERUP_DELAY - 1);
    localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_DELAY - 1);
    localparam logic [CW-1:0] SHORT_LAST = CW'(SHORT_DELAY - 1);
    localparam logic [CW-1:0] PH_LAST    = CW'(PHASE - 1);
    localparam logic [CW-1:0] E_ON       = CW'(E_SETUP);
    localparam logic [CW-1:0] E_OFF      = CW'(E_SETUP + E_WIDTH);

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      step, step_n;
    logic            cap_rs, cap_rs_n;
    logic [7:0]      cap_data, cap_data_n;
    logic            done_q, done_n;
    logic            e_win;
    logic            long_wait;
    logic [CW-1:0]   wait_last;

    // step 0..3 index the init nibbles, 4..7 the init bytes
    function automatic logic [7:0] init_byte(input logic [2:0] s);
        case (s)
            3'd4:    return 8'h28;
            3'd5:    return 8'h0C;
            3'd6:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= PWR_WAIT;
            cnt      <= '0;
            step     <= '0;
            cap_rs   <= 1'b0;
            cap_data <= '0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            step     <= step_n;
            cap_rs   <= cap_rs_n;
            cap_data <= cap_data_n;
            done_q   <= done_n;
        end
    end

    assign e_win     = (cnt >= E_ON) && (cnt < E_OFF);
    // Init nibbles and clear/home need the long settle time
    assign long_wait = (!done_q && (step < 3'd4)) || (!cap_rs && (cap_data[7:2] == 6'd0));
    assign wait_last = long_wait ? LONG_LAST : SHORT_LAST;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt + 1'b1;
        step_n     = step;
        cap_rs_n   = cap_rs;
        cap_data_n = cap_data;
        done_n     = done_q;
        rs         = 1'b0;
        e          = 1'b0;
        d          = 4'h0;
        case (state)
            PWR_WAIT: begin
                if (cnt == PWR_LAST) begin
                    state_n = INIT_NIB;
                    cnt_n   = '0;
                    step_n  = 3'd0;
                end
            end
            INIT_NIB: begin
                d = (step == 3'd3) ? 4'h2 : 4'h3;
                e = e_win;
                if (cnt == PH_LAST) begin
                    state_n = WAIT;
                    cnt_n   = '0;
                end
            end
            INIT_BYTE: begin
                cap_rs_n   = 1'b0;
                cap_data_n = init_byte(step);
                state_n    = SEND_HI;
                cnt_n      = '0;
            end
            IDLE: begin
                cnt_n = '0;
                if (req && done_q) begin
                    cap_rs_n   = req_rs;
                    cap_data_n = req_data;
                    state_n    = SEND_HI;
                end
            end
            SEND_HI: begin
                rs = cap_rs;
                d  = cap_data[7:4];
                e  = e_win;
                if (cnt == PH_LAST) begin
                    state_n = SEND_LO;
                    cnt_n   = '0;
                end
            end
            SEND_LO: begin
                rs = cap_rs;
                d  = cap_data[3:0];
                e  = e_win;
                if (cnt == PH_LAST) begin
                    state_n = WAIT;
                    cnt_n   = '0;
                end
            end
            WAIT: begin
                if (cnt == wait_last) begin
                    cnt_n = '0;
                    if (done_q) begin
                        state_n = IDLE;
                    end else if (step == 3'd7) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        step_n  = step + 3'd1;
                        state_n = (step < 3'd3) ? INIT_NIB : INIT_BYTE;
                    end
                end
            end
            default: begin
                state_n = PWR_WAIT;
                cnt_n   = '0;
            end
        endcase
    end

    assign ready     = (state == IDLE) && done_q;
    assign init_done = done_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Bench for lcd_sequencer: directed writes, a pulse scoreboard fed at issue
// time and drained by an E-strobe monitor, plus handshake timing checks.
module tb_lcd_sequencer;

    logic       clock;
    logic       reset;
    logic       req;
    logic       req_rs;
    logic [7:0] req_data;
    logic       ready;
    logic       init_done;
    logic       rs;
    logic       e;
    logic [3:0] d;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_q[$];
    logic [3:0] init_nibs[12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                  4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};

    lcd_sequencer #(
        .POWERUP_DELAY(20),
        .LONG_DELAY   (10),
        .SHORT_DELAY  (5),
        .E_SETUP      (1),
        .E_WIDTH      (3),
        .E_HOLD       (1)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .req_rs   (req_rs),
        .req_data (req_data),
        .ready    (ready),
        .init_done(init_done),
        .rs       (rs),
        .e        (e),
        .d        (d),
        .state_dbg(state_dbg)
    );

    // clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string name, input int got, input int req_v);
        checks++;
        if (got != req_v) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req_v);
        end
    endtask

    task automatic report();
        $display("Result: errors=%0d of %0d checks", errors, checks);
    endtask

    // E-strobe monitor: each completed pulse pops one expected {rs,d}
    logic       e_prev = 1'b0;
    logic       p_rs;
    logic [3:0] p_d;
    int         p_w;
    logic       p_stable;
    logic       p_abort;
    logic [4:0] exp_v;

    always @(negedge clock) begin
        if (e === 1'b1) begin
            if (e_prev !== 1'b1) begin
                p_rs = rs; p_d = d; p_w = 1; p_stable = 1'b1; p_abort = 1'b0;
            end else begin
                p_w++;
                if (rs !== p_rs || d !== p_d) p_stable = 1'b0;
            end
            if (reset === 1'b0) p_abort = 1'b1;
        end else if (e_prev === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got rs=%0d d=%h, required no pulse", p_rs, p_d);
            end else begin
                exp_v = exp_q.pop_front();
                if ({p_rs, p_d} !== exp_v) begin
                    errors++;
                    $display("FAIL pulse_value: got rs=%0d d=%h, required rs=%0d d=%h",
                             p_rs, p_d, exp_v[4], exp_v[3:0]);
                end
            end
            if (!p_abort) begin
                check_eq("pulse_width", p_w, 3);
                check_eq("pulse_rs_d_stable", int'(p_stable), 1);
            end
        end
        e_prev = e;
    end

    // driver tasks
    task automatic do_reset(input int n);
        @(posedge clock); #2;
        reset = 1'b0;
        repeat (n) @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    task automatic wait_ready(input int bound);
        int n;
        n = 0;
        @(negedge clock);
        while (ready !== 1'b1 && n < bound) begin
            @(negedge clock);
            n++;
        end
        check_eq("ready_wait", int'(ready === 1'b1), 1);
    endtask

    // Called while in the first post-reset cycle; also pokes req in PWR_WAIT.
    task automatic check_init();
        int early;
        int n;
        for (int i = 0; i < 12; i++) exp_q.push_back({1'b0, init_nibs[i]});
        @(negedge clock);
        check_eq("reset_e", int'(e), 0);
        check_eq("reset_ready", int'(ready), 0);
        check_eq("reset_init_done", int'(init_done), 0);
        check_eq("reset_rs_d", int'({rs, d}), 0);
        early = 0;
        for (int k = 1; k < 20; k++) begin
            @(negedge clock);
            if (e) early++;
            if (k >= 3 && k <= 5) begin
                req = 1'b1; req_rs = 1'b1; req_data = 8'h55;
            end else begin
                req = 1'b0;
            end
        end
        req = 1'b0;
        check_eq("powerup_no_e", early, 0);
        n = 0;
        while (ready !== 1'b1 && n < 300) begin
            @(negedge clock);
            n++;
        end
        check_eq("init_ready", int'(ready === 1'b1), 1);
        check_eq("init_done_high", int'(init_done), 1);
    endtask

    // Single write; gap = cycles from acceptance to ready returning.
    task automatic write_byte(input logic rs_i, input logic [7:0] data_i,
                              input int gap, input bit poke_lo);
        int k;
        wait_ready(100);
        req = 1'b1; req_rs = rs_i; req_data = data_i;
        exp_q.push_back({rs_i, data_i[7:4]});
        exp_q.push_back({rs_i, data_i[3:0]});
        @(negedge clock);
        req = 1'b0; req_rs = ~rs_i; req_data = ~data_i;
        check_eq("ready_low_after_accept", int'(ready), 0);
        k = 1;
        while (ready !== 1'b1 && k < 100) begin
            @(negedge clock);
            k++;
            if (poke_lo && k == 7) begin
                req = 1'b1; req_rs = 1'b1; req_data = 8'hAA;
            end
            if (k == 8) req = 1'b0;
        end
        check_eq($sformatf("write_gap_%02h", data_i), k, gap);
    endtask

    task automatic back_to_back();
        int k;
        wait_ready(100);
        req = 1'b1; req_rs = 1'b1; req_data = 8'h41;
        exp_q.push_back({1'b1, 4'h4});
        exp_q.push_back({1'b1, 4'h1});
        @(negedge clock);
        req_data = 8'h42;
        exp_q.push_back({1'b1, 4'h4});
        exp_q.push_back({1'b1, 4'h2});
        check_eq("b2b_ready_low", int'(ready), 0);
        k = 1;
        while (ready !== 1'b1 && k < 100) begin
            @(negedge clock);
            k++;
        end
        check_eq("b2b_spacing", k, 16);
        @(negedge clock);
        req = 1'b0;
        check_eq("b2b_second_taken", int'(ready), 0);
    endtask

    task automatic reset_mid_write();
        int   rises;
        logic prev;
        wait_ready(100);
        req = 1'b1; req_rs = 1'b1; req_data = 8'h48;
        exp_q.push_back({1'b1, 4'h4});
        exp_q.push_back({1'b1, 4'h8});
        @(negedge clock);
        req = 1'b0;
        rises = 0;
        prev = 1'b0;
        for (int n = 0; n < 40 && rises < 2; n++) begin
            @(negedge clock);
            if (e && !prev) rises++;
            prev = e;
        end
        check_eq("second_pulse_seen", rises, 2);
        do_reset(1);
        check_init();
    endtask

    // main sequence
    initial begin
        reset = 1'b0; req = 1'b0; req_rs = 1'b0; req_data = 8'h00;
        do_reset(3);
        check_init();
        write_byte(1'b1, 8'h48, 16, 1'b0);
        write_byte(1'b0, 8'h01, 21, 1'b1);
        back_to_back();
        write_byte(1'b0, 8'h02, 21, 1'b0);
        write_byte(1'b0, 8'h04, 16, 1'b0);
        write_byte(1'b1, 8'h01, 16, 1'b0);
        reset_mid_write();
        write_byte(1'b1, 8'h48, 16, 1'b0);
        repeat (30) @(negedge clock);
        check_eq("scoreboard_empty", exp_q.size(), 0);
        report();
        $finish;
    end

    initial begin
        #200000;
        errors++;
        checks++;
        $display("FAIL watchdog: got timeout, required completion");
        report();
        $finish;
    end

endmodule
